// File: rtl/multisim_server_push_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ valid/ready requesters into one push-server channel.
// Each accepted beat is registered with its source index; a burst limit forces rotation under contention.
module multisim_server_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int MAX_BURST  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             in_vld,
    output logic [NUM_REQ-1:0]             in_rdy,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  in_data,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] out_data,
    output logic                           busy,
    output logic [1:0]                     state,
    output logic [ID_WIDTH-1:0]            ptr
);

    localparam int                OUT_W     = ID_WIDTH + DATA_WIDTH;
    localparam logic [7:0]        BURST_LIM = 8'(MAX_BURST);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    // Handshake: a beat moves across a port on a rising edge where its vld and rdy are both high.
    // IDLE = output empty, SEND = held beat consumed this cycle, STALL = held beat blocked.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } phase_t;

    phase_t                phase;
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
    logic                  load;
    logic                  gnt_found;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [ID_WIDTH-1:0]   ptr_nxt;
    logic [7:0]            burst_cnt;
    logic [7:0]            cnt_nxt;
    logic [7:0]            run_len;
    logic                  vld_nxt;
    logic [OUT_W-1:0]      data_nxt;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_found && in_vld[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        vld_nxt  = out_vld;
        data_nxt = out_data;
        ptr_nxt  = ptr;
        cnt_nxt  = burst_cnt;
        run_len  = 8'd0;
        in_rdy   = '0;
        load     = !out_vld || out_rdy;

        if (!out_vld) begin
            phase = IDLE;
        end else if (out_rdy) begin
            phase = SEND;
        end else begin
            phase = STALL;
        end

        if (load) begin
            if (gnt_found) begin
                in_rdy[gnt_idx] = rst_n;
                vld_nxt         = 1'b1;
                data_nxt        = {gnt_idx, req_data[gnt_idx]};
                // ptr only sits on g while a burst is running, so ptr == g means "same grantee".
                run_len = (gnt_idx == ptr) ? burst_cnt + 8'd1 : 8'd1;
                if (run_len < BURST_LIM) begin
                    ptr_nxt = gnt_idx;
                    cnt_nxt = run_len;
                end else begin
                    ptr_nxt = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
                    cnt_nxt = 8'd0;
                end
            end else begin
                vld_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_data  <= '0;
            ptr       <= '0;
            burst_cnt <= 8'd0;
        end else begin
            out_vld   <= vld_nxt;
            out_data  <= data_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    assign busy  = out_vld || (|in_vld);
    assign state = phase;

endmodule

// File: tb/tb_multisim_server_push_arbiter.sv
// Bench for multisim_server_push_arbiter: two instances (MAX_BURST 1 and 4) share stimulus,
// each row carries hand-derived grants and pointer values; beats are tracked in expected queues.
module tb_multisim_server_push_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int IW = 2;
    localparam int OW = IW + DW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    in_vld = '0;
    logic [NR*DW-1:0] in_data = '0;
    logic             out_rdy = 1'b0;

    logic [NR-1:0] in_rdy_x   [2];
    logic          out_vld_x  [2];
    logic [OW-1:0] out_data_x [2];
    logic          busy_x     [2];
    logic [1:0]    state_x    [2];
    logic [IW-1:0] ptr_x      [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [OW-1:0] exp_q_a[$];
    logic [OW-1:0] exp_q_b[$];

    typedef struct {
        logic [3:0]      vld;
        logic            rdy;
        logic            fix3;
        logic [1:0]      acc;
        logic [1:0][1:0] id;
        logic [1:0][1:0] ptr;
    } row_t;

    row_t rows[40];

    always #5 clk = ~clk;

    multisim_server_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy_x[0]), .in_data(in_data),
        .out_vld(out_vld_x[0]), .out_rdy(out_rdy), .out_data(out_data_x[0]),
        .busy(busy_x[0]), .state(state_x[0]), .ptr(ptr_x[0])
    );

    multisim_server_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) u_bl (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy_x[1]), .in_data(in_data),
        .out_vld(out_vld_x[1]), .out_rdy(out_rdy), .out_data(out_data_x[1]),
        .busy(busy_x[1]), .state(state_x[1]), .ptr(ptr_x[1])
    );

    function automatic row_t mk(input int vld, input int rdy, input int fix3,
                                input int acc_a, input int id_a, input int ptr_a,
                                input int acc_b, input int id_b, input int ptr_b);
        row_t r;
        r.vld    = 4'(vld);
        r.rdy    = 1'(rdy);
        r.fix3   = 1'(fix3);
        r.acc[0] = 1'(acc_a);
        r.acc[1] = 1'(acc_b);
        r.id[0]  = 2'(id_a);
        r.id[1]  = 2'(id_b);
        r.ptr[0] = 2'(ptr_a);
        r.ptr[1] = 2'(ptr_b);
        return r;
    endfunction

    function automatic int q_size(input int u);
        return (u == 0) ? exp_q_a.size() : exp_q_b.size();
    endfunction

    function automatic logic [OW-1:0] q_front(input int u);
        return (u == 0) ? exp_q_a[0] : exp_q_b[0];
    endfunction

    task automatic q_pop(input int u);
        if (u == 0) void'(exp_q_a.pop_front());
        else        void'(exp_q_b.pop_front());
    endtask

    task automatic q_push(input int u, input logic [OW-1:0] beat);
        if (u == 0) exp_q_a.push_back(beat);
        else        exp_q_b.push_back(beat);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_row(input row_t r);
        in_vld  = r.vld;
        out_rdy = r.rdy;
        for (int i = 0; i < NR; i++) begin
            in_data[i*DW +: DW] = {$urandom, $urandom};
        end
        if (r.fix3) in_data[3*DW +: DW] = 64'hA5;
    endtask

    // Compare one instance against its expected queue in the cycle before the edge.
    task automatic score_cycle(input int u, input int idx, input row_t r);
        int            n;
        logic [3:0]    exp_rdy;
        logic [1:0]    exp_state;
        logic [DW-1:0] payload;
        n         = q_size(u);
        exp_rdy   = r.acc[u] ? (4'b0001 << r.id[u]) : 4'b0000;
        exp_state = (n == 0) ? 2'd0 : (out_rdy ? 2'd1 : 2'd2);
        check($sformatf("in_rdy[%0d] row %0d", u, idx), 128'(in_rdy_x[u]), 128'(exp_rdy));
        check($sformatf("out_vld[%0d] row %0d", u, idx), 128'(out_vld_x[u]), 128'(n > 0));
        check($sformatf("busy[%0d] row %0d", u, idx), 128'(busy_x[u]), 128'((n > 0) || (|in_vld)));
        check($sformatf("state[%0d] row %0d", u, idx), 128'(state_x[u]), 128'(exp_state));
        if (n > 0) begin
            check($sformatf("out_data[%0d] row %0d", u, idx), 128'(out_data_x[u]), 128'(q_front(u)));
            if (out_rdy) q_pop(u);
        end
        if (r.acc[u]) begin
            payload = in_data[r.id[u]*DW +: DW];
            q_push(u, {r.id[u], payload});
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive_row(rows[i]);
            #1;
            for (int u = 0; u < 2; u++) score_cycle(u, i, rows[i]);
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                check($sformatf("ptr[%0d] row %0d", u, i), 128'(ptr_x[u]), 128'(rows[i].ptr[u]));
                if (rows[i].fix3) begin
                    check($sformatf("a5_beat[%0d]", u), 128'(out_data_x[u]), 128'({2'd3, 64'hA5}));
                end
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s in_rdy[%0d]", tag, u), 128'(in_rdy_x[u]), 128'(0));
            check($sformatf("%s out_vld[%0d]", tag, u), 128'(out_vld_x[u]), 128'(0));
            check($sformatf("%s out_data[%0d]", tag, u), 128'(out_data_x[u]), 128'(0));
            check($sformatf("%s ptr[%0d]", tag, u), 128'(ptr_x[u]), 128'(0));
            check($sformatf("%s busy[%0d]", tag, u), 128'(busy_x[u]), 128'(|in_vld));
        end
    endtask

    initial begin
        // Columns: vld, rdy, fix3 | acc, id, ptr-after for MAX_BURST=1 | same for MAX_BURST=4
        rows[0]  = mk(4'hF, 1, 0, 1, 0, 1, 1, 0, 0);
        rows[1]  = mk(4'hF, 1, 0, 1, 1, 2, 1, 0, 0);
        rows[2]  = mk(4'hF, 1, 0, 1, 2, 3, 1, 0, 0);
        rows[3]  = mk(4'hF, 1, 0, 1, 3, 0, 1, 0, 1);
        rows[4]  = mk(4'hF, 1, 0, 1, 0, 1, 1, 1, 1);
        rows[5]  = mk(4'hF, 1, 0, 1, 1, 2, 1, 1, 1);
        rows[6]  = mk(4'hF, 1, 0, 1, 2, 3, 1, 1, 1);
        rows[7]  = mk(4'hF, 1, 0, 1, 3, 0, 1, 1, 2);
        rows[8]  = mk(4'h6, 1, 0, 1, 1, 2, 1, 2, 2);
        rows[9]  = mk(4'h6, 1, 0, 1, 2, 3, 1, 2, 2);
        rows[10] = mk(4'h6, 1, 0, 1, 1, 2, 1, 2, 2);
        rows[11] = mk(4'h6, 1, 0, 1, 2, 3, 1, 2, 3);
        rows[12] = mk(4'h6, 1, 0, 1, 1, 2, 1, 1, 1);
        rows[13] = mk(4'h6, 1, 0, 1, 2, 3, 1, 1, 1);
        rows[14] = mk(4'h6, 1, 0, 1, 1, 2, 1, 1, 1);
        rows[15] = mk(4'h6, 1, 0, 1, 2, 3, 1, 1, 2);
        rows[16] = mk(4'h6, 1, 0, 1, 1, 2, 1, 2, 2);
        rows[17] = mk(4'h2, 1, 0, 1, 1, 2, 1, 1, 1);
        rows[18] = mk(4'h2, 1, 0, 1, 1, 2, 1, 1, 1);
        rows[19] = mk(4'h2, 1, 0, 1, 1, 2, 1, 1, 1);
        rows[20] = mk(4'h2, 1, 0, 1, 1, 2, 1, 1, 2);
        rows[21] = mk(4'h2, 1, 0, 1, 1, 2, 1, 1, 1);
        rows[22] = mk(4'h2, 1, 0, 1, 1, 2, 1, 1, 1);
        rows[23] = mk(4'h8, 1, 1, 1, 3, 0, 1, 3, 3);
        for (int i = 24; i <= 28; i++) rows[i] = mk(4'hF, 0, 0, 0, 0, 0, 0, 0, 3);
        rows[29] = mk(4'hF, 1, 0, 1, 0, 1, 1, 3, 3);
        rows[30] = mk(4'h4, 1, 0, 1, 2, 3, 1, 2, 2);
        rows[31] = mk(4'h1, 1, 0, 1, 0, 1, 1, 0, 0);
        for (int i = 32; i <= 34; i++) rows[i] = mk(4'h0, 1, 0, 0, 0, 1, 0, 0, 0);
        rows[35] = mk(4'h4, 0, 0, 1, 2, 3, 1, 2, 2);
        rows[36] = mk(4'h4, 0, 0, 0, 0, 3, 0, 0, 2);
        rows[37] = mk(4'hF, 1, 0, 1, 0, 1, 1, 0, 0);
        rows[38] = mk(4'h0, 1, 0, 0, 0, 1, 0, 0, 0);
        rows[39] = mk(4'h0, 1, 0, 0, 0, 1, 0, 0, 0);

        // Reset with every requester asserting.
        rst_n   = 1'b0;
        in_vld  = 4'hF;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_state("reset");
        in_vld = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_rows(0, 36);

        // Both instances now hold a stalled beat; reset must drop it without a clock edge.
        rst_n = 1'b0;
        #1;
        check_reset_state("stall_reset");
        for (int u = 0; u < 2; u++) begin
            check($sformatf("stall_reset state[%0d]", u), 128'(state_x[u]), 128'(0));
        end
        exp_q_a.delete();
        exp_q_b.delete();
        in_vld = 4'h0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_rows(37, 39);

        for (int u = 0; u < 2; u++) begin
            check($sformatf("drain[%0d]", u), 128'(q_size(u)), 128'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
